// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared constants and helpers for the single-cycle data memory.
//   MIPS_DATA_WIDTH / MIPS_ADDR_WIDTH : default datapath word and byte-address widths
//   DEF_MMIO_ADDR                     : default byte address of the output register
//   clog2()                           : index width for a word array of a given depth
package data_mem_pkg;

    localparam int MIPS_DATA_WIDTH = 32;
    localparam int MIPS_ADDR_WIDTH = 32;
    localparam logic [31:0] DEF_MMIO_ADDR = 32'h0000_FFFC;

    // Ceiling log2, usable in constant expressions (parameter defaults).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/data_mem_addr_dec.sv
// dmem_addr_dec
// Combinational decode of a byte address for the data memory.
//   addr       in  byte address
//   index      out word index, addr[IDX_WIDTH+1:2]
//   in_range   out address falls inside the word array (addr < 4 * 2**IDX_WIDTH)
//   is_mmio    out address hits the output register (only when MMIO_EN is set)
//   misaligned out low two address bits are non-zero
module dmem_addr_dec
    import data_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = MIPS_ADDR_WIDTH,
    parameter int                    IDX_WIDTH  = 6,
    parameter bit                    MMIO_EN    = 1'b0,
    parameter logic [ADDR_WIDTH-1:0] MMIO_ADDR  = ADDR_WIDTH'(DEF_MMIO_ADDR)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_WIDTH-1:0]  index,
    output logic                  in_range,
    output logic                  is_mmio,
    output logic                  misaligned
);

    assign index      = addr[IDX_WIDTH+1:2];
    // Every bit above the array span must be zero for the address to be decoded.
    assign in_range   = (addr[ADDR_WIDTH-1:IDX_WIDTH+2] == '0);
    // The array wins if the register address were ever placed inside it.
    assign is_mmio    = MMIO_EN && !in_range && (addr == MMIO_ADDR);
    assign misaligned = |addr[1:0];

endmodule

// File: rtl/data_mem.sv
// data_mem
// Word-organised data memory for a single-cycle datapath: combinational read,
// store committed on the rising clock edge, sticky access-error flags and a
// saturating store counter. Optional output register enabled by DMEM_MMIO_EN.
//   CLK          in  clock, all state changes on the rising edge
//   RST          in  synchronous reset, active low
//   ADDR         in  byte address (ALU result)
//   WD           in  store data (register-file RD2)
//   WE           in  store enable
//   RE           in  load qualifier, only used for error flagging
//   RD           out load data, combinational, old data during a same-word store
//   MISALIGN_ERR out sticky: access with ADDR[1:0] != 0
//   RANGE_ERR    out sticky: access outside the array and not at the output register
//   ST_CNT       out committed stores, saturating at all-ones
//   IO_OUT       out output register (zero without DMEM_MMIO_EN)
//   IO_VALID     out one-cycle pulse after an output-register store (zero without DMEM_MMIO_EN)
module data_mem
    import data_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH = MIPS_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = MIPS_ADDR_WIDTH,
    parameter int                    DEPTH      = 64,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] MMIO_ADDR  = ADDR_WIDTH'(DEF_MMIO_ADDR)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WE,
    input  logic                  RE,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  MISALIGN_ERR,
    output logic                  RANGE_ERR,
    output logic [CNT_WIDTH-1:0]  ST_CNT,
    output logic [DATA_WIDTH-1:0] IO_OUT,
    output logic                  IO_VALID
);

    localparam int IDX_WIDTH = clog2(DEPTH);

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic [IDX_WIDTH-1:0]  index;
    logic                  in_range;
    logic                  is_mmio;
    logic                  misaligned;
    logic                  access;
    logic                  commit_mem;
    logic                  commit_io;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    dmem_addr_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH),
        .MMIO_EN    (MMIO_EN),
        .MMIO_ADDR  (MMIO_ADDR)
    ) u_dec (
        .addr       (ADDR),
        .index      (index),
        .in_range   (in_range),
        .is_mmio    (is_mmio),
        .misaligned (misaligned)
    );

    assign access     = WE | RE;
    assign commit_mem = WE & in_range;
    // is_mmio is constant zero when no output register is built.
    assign commit_io  = WE & is_mmio;

    // Array, counter and sticky flags. Reset overrides a store in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            ST_CNT       <= '0;
            MISALIGN_ERR <= 1'b0;
            RANGE_ERR    <= 1'b0;
        end else begin
            // A misaligned store still lands on the word selected by the index.
            if (commit_mem) begin
                mem[index] <= WD;
            end
            if ((commit_mem || commit_io) && (ST_CNT != '1)) begin
                ST_CNT <= ST_CNT + 1'b1;
            end
            if (access && misaligned) begin
                MISALIGN_ERR <= 1'b1;
            end
            if (access && !in_range && !is_mmio) begin
                RANGE_ERR <= 1'b1;
            end
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            IO_OUT   <= '0;
            IO_VALID <= 1'b0;
        end else begin
            if (commit_io) begin
                IO_OUT <= WD;
            end
            // Re-armed on every register store, so back-to-back stores hold it high.
            IO_VALID <= commit_io;
        end
    end
`else
    assign IO_OUT   = '0;
    assign IO_VALID = 1'b0;
`endif

    // Read path: no bypass, a same-cycle store to the same word returns old data.
    always_comb begin
        RD = '0;
        if (in_range) begin
            RD = mem[index];
        end else if (is_mmio) begin
            RD = IO_OUT;
        end
    end

endmodule

// File: doc/data_mem.md
# data_mem

Word-organised data memory sitting directly downstream of the single-cycle datapath: it takes the ALU result as a byte address and the register-file second read port as store data, and returns load data to the write-back mux. Reads are combinational and writes commit on the clock edge, matching single-cycle timing. It also provides sticky access-error flags and a saturating store counter for verification. An optional memory-mapped output register gives test programs a visible result port.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte-address width
- DEPTH, 64, number of words; power of two, 4..1024
- CNT_WIDTH, 16, store-counter width
- MMIO_ADDR, 32'h0000_FFFC, byte address of the output register (used only with DMEM_MMIO_EN)

Ports:
- CLK  in  1  single clock, all state changes on rising edge
- RST  in  1  synchronous reset, active low; sampled on the rising edge of CLK
- ADDR  in  ADDR_WIDTH  byte address (from ALUResult)
- WD  in  DATA_WIDTH  store data (from register-file RD2)
- WE  in  1  store enable (MemWrite)
- RE  in  1  load qualifier (MemtoReg); used only for error flagging
- RD  out  DATA_WIDTH  load data, combinational
- MISALIGN_ERR  out  1  sticky: an access with ADDR[1:0] != 0 occurred
- RANGE_ERR  out  1  sticky: an access outside the decoded range occurred
- ST_CNT  out  CNT_WIDTH  number of committed stores, saturating
- IO_OUT  out  DATA_WIDTH  output register (all zero when macro absent)
- IO_VALID  out  1  one-cycle pulse after an output-register write (0 when macro absent)

## Operation
- Index = ADDR[log2(DEPTH)+1:2]. In range: ADDR < DEPTH*4. An access is a cycle with WE=1 or RE=1.
- Read: RD = mem[index] when in range; RD = IO_OUT when ADDR == MMIO_ADDR (macro on); otherwise RD = 0. ADDR[1:0] is ignored for data selection.
- Store (WE=1, RST=1), in range: mem[index] <= WD. ST_CNT increments, holding at all-ones.
- Store at MMIO_ADDR (macro on): IO_OUT <= WD, IO_VALID = 1 next cycle, and ST_CNT increments.
- Store elsewhere: dropped. RANGE_ERR is set and ST_CNT is unchanged.
- Misaligned store: commits to the word selected by the index, and MISALIGN_ERR is set.
- Any access out of range and not at MMIO_ADDR sets RANGE_ERR. When WE=0 and RE=0, nothing is flagged.
- Error flags clear only on reset.

## Timing
- Reset (RST=0 at an edge): all mem words, IO_OUT, ST_CNT, IO_VALID, MISALIGN_ERR and RANGE_ERR go to 0. Reset overrides WE in the same cycle.
- Read latency is 0 cycles (combinational from ADDR and state). Store latency is 1 edge.
- Read and write to the same word in the same cycle: RD returns the old data, and the new data is visible after the edge. No bypass.
- IO_VALID is high for exactly the one cycle following each MMIO store. Back-to-back MMIO stores keep it high continuously.
- ST_CNT at all-ones plus a further store: stays all-ones, no wrap.
- Flags assert in the cycle after the offending edge.

## Configuration
- DMEM_MMIO_EN defined: the output register at MMIO_ADDR is decoded for both read and write, and drives IO_OUT and IO_VALID.
- DMEM_MMIO_EN undefined: no register is built. IO_OUT and IO_VALID are tied to 0, and MMIO_ADDR is treated as out of range (reads return 0, stores are dropped, RANGE_ERR is set).

## Structure
- The shared package holds the MIPS width constants (DATA_WIDTH, ADDR_WIDTH), the default MMIO_ADDR constant, and an index-width function (clog2).
- One sub-module, dmem_addr_dec: combinational decode of ADDR into index, in_range, is_mmio and misaligned. The array, output register, counter and flags live in data_mem.

## Test plan
- Reset, then read addresses 0x00..0xFC: RD = 0 everywhere; ST_CNT = 0; all flags 0.
- SW 0xDEADBEEF @0x08 and 0x12345678 @0x0C, then read both: RD matches; ST_CNT = 2; neighbouring word 0x04 reads 0.
- Same-cycle read and write @0x10 (old 0x1, new 0x2): RD = 0x1 in that cycle and 0x2 in the next.
- Store @0x0102 (misaligned, in range): word 0x0100 is written only if DEPTH > 64; with DEPTH = 64 it is dropped, and both MISALIGN_ERR and RANGE_ERR = 1. Store @0x05: word 0x04 is written and MISALIGN_ERR = 1.
- With macro on, store 0xCAFE @0xFFFC: IO_OUT = 0xCAFE, IO_VALID high for exactly one cycle, readback = 0xCAFE. With macro off: RANGE_ERR = 1 and IO_OUT = 0.
- CNT_WIDTH = 4, 17 stores: ST_CNT = 15. Assert RST=0 mid-sequence with WE=1: that store is not committed and all state reads 0 afterwards.
